// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I instruction-decode stage.
//   Sits between fetch and execute with a valid/ready handshake on both sides.
//   It decodes control signals and the sign-extended immediate, and inserts a
//   one-cycle bubble when the incoming instruction reads the result of a load
//   that is still in this stage.
//   Optional feature macro: ID_ILLEGAL_CHECK_EN adds out_illegal. When it is
//   set, unknown opcodes are flagged and still passed downstream.
module id_stage_pipe #(
  parameter int WORD_BITWIDTH    = 32,  // only 32 is supported
  parameter int REG_NUM_BITWIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_BITWIDTH-1:0]    in_instr,
  input  logic [WORD_BITWIDTH-1:0]    in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_BITWIDTH-1:0]    out_pc,
  output logic [REG_NUM_BITWIDTH-1:0] out_rs1,
  output logic [REG_NUM_BITWIDTH-1:0] out_rs2,
  output logic [REG_NUM_BITWIDTH-1:0] out_rd,
  output logic [6:0]                  out_opcode,
  output logic [WORD_BITWIDTH-1:0]    out_imm,
  output logic                        out_branch,
  output logic                        out_jump,
  output logic                        out_memRead,
  output logic                        out_memToReg,
  output logic                        out_memWrite,
  output logic                        out_ALUSrc,
  output logic                        out_regWrite,
`ifdef ID_ILLEGAL_CHECK_EN
  output logic                        out_illegal,
`endif
  output logic [1:0]                  out_ALUOp
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  // Field order matches the control table: branch, jump, memRead, memToReg,
  // memWrite, ALUSrc, regWrite, ALUOp.
  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [1:0] aluOp;
  } ctrl_t;

  logic [6:0]                  opcode;
  logic [REG_NUM_BITWIDTH-1:0] rs1Idx;
  logic [REG_NUM_BITWIDTH-1:0] rs2Idx;
  logic [REG_NUM_BITWIDTH-1:0] rdIdx;
  ctrl_t                       decCtrl;
  logic [WORD_BITWIDTH-1:0]    decImm;
  logic                        decKnown;
  logic                        readsRs1;
  logic                        readsRs2;
  logic                        loadUseHazard;
  logic                        canAdvance;
  logic                        acceptIn;
  ctrl_t                       outCtrl;

  assign opcode = in_instr[6:0];
  assign rs1Idx = in_instr[19:15];
  assign rs2Idx = in_instr[24:20];
  assign rdIdx  = in_instr[11:7];

  // Combinational decode of control, immediate and source-register usage.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    decCtrl  = '0;
    decImm   = '0;
    decKnown = 1'b1;
    readsRs1 = 1'b1;
    readsRs2 = 1'b0;
    case (opcode)
      OP_R: begin
        decCtrl  = ctrl_t'(9'b0000001_10);
        readsRs2 = 1'b1;
      end
      OP_LOAD: begin
        decCtrl = ctrl_t'(9'b0011011_00);
        decImm  = {{(WORD_BITWIDTH-12){in_instr[31]}}, in_instr[31:20]};
      end
      OP_IMM: begin
        decCtrl = ctrl_t'(9'b0000011_11);
        decImm  = {{(WORD_BITWIDTH-12){in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        decCtrl  = ctrl_t'(9'b0000110_00);
        decImm   = {{(WORD_BITWIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        readsRs2 = 1'b1;
      end
      OP_BRANCH: begin
        decCtrl  = ctrl_t'(9'b1000000_01);
        decImm   = {{(WORD_BITWIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
        readsRs2 = 1'b1;
      end
      OP_JAL: begin
        decCtrl  = ctrl_t'(9'b0100001_00);
        decImm   = {{(WORD_BITWIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
        readsRs1 = 1'b0;
      end
      OP_JALR: begin
        decCtrl = ctrl_t'(9'b0100011_00);
        decImm  = {{(WORD_BITWIDTH-12){in_instr[31]}}, in_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        decCtrl  = ctrl_t'(9'b0000011_00);
        decImm   = {in_instr[31:12], 12'b0};
        readsRs1 = 1'b0;
      end
      default: begin
        decKnown = 1'b0;
      end
    endcase
  end

  // A load still in this stage cannot forward its data yet, so a dependent
  // instruction has to wait one cycle behind it.
  assign loadUseHazard = out_valid & outCtrl.memRead & (out_rd != '0) &
                         ((readsRs1 & (rs1Idx == out_rd)) |
                          (readsRs2 & (rs2Idx == out_rd)));

  assign canAdvance = !out_valid | out_ready;
  // Reset also blocks acceptance so fetch does not see a handshake that the
  // register bank would ignore.
  assign in_ready   = !rst & !flush & !loadUseHazard & canAdvance;
  assign acceptIn   = in_valid & in_ready;

  // Output register bank: rst > flush > hazard bubble > normal load, holds on stall.
  // NOTE: sequential state uses non-blocking assignments; the reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_rs1    <= '0;
      out_rs2    <= '0;
      out_rd     <= '0;
      out_opcode <= '0;
      out_imm    <= '0;
      outCtrl    <= '0;
`ifdef ID_ILLEGAL_CHECK_EN
      out_illegal <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (canAdvance) begin
      // A hazard or an idle fetch leaves a bubble; the data fields keep their old values.
      out_valid <= acceptIn;
      if (acceptIn) begin
        out_pc     <= in_pc;
        out_rs1    <= rs1Idx;
        out_rs2    <= rs2Idx;
        out_rd     <= rdIdx;
        out_opcode <= opcode;
        out_imm    <= decImm;
        outCtrl    <= decCtrl;
`ifdef ID_ILLEGAL_CHECK_EN
        out_illegal <= !decKnown;
`endif
      end
    end
  end

`ifndef ID_ILLEGAL_CHECK_EN
  // Without the trap check, unknown opcodes simply decode to all-zero control.
  logic unusedKnown;
  assign unusedKnown = decKnown;
`endif

  assign out_branch   = outCtrl.branch;
  assign out_jump     = outCtrl.jump;
  assign out_memRead  = outCtrl.memRead;
  assign out_memToReg = outCtrl.memToReg;
  assign out_memWrite = outCtrl.memWrite;
  assign out_ALUSrc   = outCtrl.aluSrc;
  assign out_regWrite = outCtrl.regWrite;
  assign out_ALUOp    = outCtrl.aluOp;

endmodule
